ext_write_post_buffer: RTL
==========================

Name: ext_write_post_buffer

Overview:
- Sits between the internal system's external-memory port (core, L1/L2 miss path) and external_memory_system_2.
- Absorbs single-word writes into a small posted-write FIFO and acknowledges them immediately.
- Forwards every other request (reads, block requests, clear) in order, only after all earlier posted writes have drained.
- Removes write stalls on the core side without breaking read-after-write ordering to DDR3.

Parameters:
- BW_ADDR, 27, word-address width (matches `BW_WORD_ADDR).
- DEPTH, 4, posted-write FIFO entries (power of two, >=2).

Ports:
- clock_i  in  1  system clock (40 MHz domain).
- resetn_i  in  1  asynchronous, active-low reset.
- core_req_i  in  1  request strobe from the internal system.
- core_reqBlock_i  in  1  block (cache line) request.
- core_rw_i  in  1  1=write, 0=read.
- core_clear_i  in  1  clear request.
- core_add_i  in  BW_ADDR  word address.
- core_data_i  in  32  write data; passed through during forwarded block writes.
- core_ready_o  out  1  buffer can accept a request this cycle.
- core_done_o  out  1  request-complete pulse.
- core_valid_o  out  1  read-data-valid pulse.
- core_data_o  out  32  read data.
- mem_req_o, mem_reqBlock_o, mem_rw_o, mem_clear_o  out  1 each  request to the external system.
- mem_add_o  out  BW_ADDR  address to the external system.
- mem_data_o  out  32  write data to the external system.
- mem_ready_i, mem_done_i, mem_valid_i  in  1 each  external system handshake.
- mem_data_i  in  32  read data from the external system.
- occupancy_o  out  log2(DEPTH)+1  FIFO fill level, for the peripheral/status path.

Behaviour:
- Handshake: a request transfers when req and ready are high in the same cycle, on both sides. At most one request is outstanding downstream; it ends with the mem_done_i pulse.
- Classification: posted = req & rw & !reqBlock & !clear. All other requests are non-posted.
- States and transitions:
  - IDLE -> DRAIN_WAIT when FIFO non-empty, mem_req_o=1 and mem_ready_i=1 (head entry popped on transfer).
  - DRAIN_WAIT -> IDLE on mem_done_i.
  - IDLE -> HOLD when a non-posted request is accepted.
  - HOLD -> DRAIN_WAIT while the FIFO is non-empty.
  - HOLD -> FWD_WAIT when the FIFO is empty and the held request transfers downstream.
  - FWD_WAIT -> IDLE on mem_done_i.
- core_ready_o:
  - IDLE: !full.
  - DRAIN_WAIT entered from IDLE: !full.
  - Any state with a held non-posted request (HOLD, FWD_WAIT, or DRAIN_WAIT while a request is held): 0.
- Posted write: pushed {add,data} on accept; core_done_o pulses exactly 1 cycle later. core_valid_o is never asserted for a posted write.
- Non-posted request: captured into a hold register; issued only when the FIFO is empty and nothing is outstanding.
  - In FWD_WAIT, mem_valid_i/mem_data_i pass combinationally to core_valid_o/core_data_o, and mem_done_i passes to core_done_o.
  - core_data_i passes to mem_data_o for block writes.
- Drain: issues head entry with mem_rw_o=1, mem_reqBlock_o=0. Drain completions are not reflected on core_done_o.
- Push and pop in the same cycle: occupancy unchanged. Full: posted writes stall via core_ready_o=0.
- Pointers wrap modulo DEPTH. occupancy ranges 0..DEPTH.
- Two core_done_o sources cannot collide: a posted ack occurs only when no non-posted request is held.
- Reset (asynchronous, any time, including mid-transaction):
  - State=IDLE, FIFO emptied (pointers/occupancy 0), hold register cleared.
  - All outputs 0, occupancy_o=0; core_ready_o returns to 1 the first cycle after reset deasserts.
  - Buffered writes are discarded.

Test Plan:
- Post 4 writes (add 0x10..0x13, data 0xA0..0xA3) with mem_ready_i=0 -> core_done_o pulses after each; occupancy_o=4; core_ready_o=0 on the 5th request.
- Release mem_ready_i, give mem_done_i 2 cycles after each transfer -> downstream sees writes 0x10..0x13 in order; occupancy_o decrements to 0.
- 2 posted writes, then a read of 0x11 -> the read reaches mem_req_o only after both write done pulses; data 0xDEADBEEF returns with core_valid_o, then core_done_o.
- Block read (reqBlock=1) with 4 mem_valid_i beats -> 4 core_valid_o pulses with matching data, one core_done_o; core_ready_o=0 throughout.
- Posted write accepted in the same cycle a drain pop transfers -> occupancy_o unchanged (2->2).
- Assert resetn_i low during DRAIN_WAIT with 3 entries -> all outputs 0, occupancy_o=0 immediately; after release core_ready_o=1 and no stale mem_req_o.

Source files
------------

// File: rtl/ext_write_post_buffer.sv
// ext_write_post_buffer
//
// Sits between the core-side external-memory port and the external memory
// system. Single-word writes are posted into a small FIFO and acknowledged
// one cycle after acceptance. Every other request (reads, block requests,
// clear) is held and forwarded in order, only after all earlier posted
// writes have drained, so read-after-write ordering is preserved.
//
// Ports
//   clock_i / resetn_i          clock, asynchronous active-low reset
//   core_*_i                    request from the internal system
//   core_ready_o                buffer can accept a request this cycle
//   core_done_o                 completion pulse (posted ack or forwarded done)
//   core_valid_o / core_data_o  read data from a forwarded request
//   mem_*_o                     request to the external system
//   mem_ready_i / mem_done_i    downstream handshake
//   mem_valid_i / mem_data_i    downstream read data
//   occupancy_o                 posted-write FIFO fill level (0..DEPTH)
//
// State        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | nothing outstanding, no held request; drains FIFO head
// S_DRAIN_WAIT | a drained write is outstanding downstream, wait mem_done_i
// S_HOLD       | non-posted request held; drain FIFO first, then forward it
// S_FWD_WAIT   | held request forwarded; pass read data/done back to core

module ext_write_post_buffer #(
    parameter int BW_ADDR = 27,
    parameter int DEPTH   = 4
) (
    input  logic                       clock_i,
    input  logic                       resetn_i,
    input  logic                       core_req_i,
    input  logic                       core_reqBlock_i,
    input  logic                       core_rw_i,
    input  logic                       core_clear_i,
    input  logic [BW_ADDR-1:0]         core_add_i,
    input  logic [31:0]                core_data_i,
    output logic                       core_ready_o,
    output logic                       core_done_o,
    output logic                       core_valid_o,
    output logic [31:0]                core_data_o,
    output logic                       mem_req_o,
    output logic                       mem_reqBlock_o,
    output logic                       mem_rw_o,
    output logic                       mem_clear_o,
    output logic [BW_ADDR-1:0]         mem_add_o,
    output logic [31:0]                mem_data_o,
    input  logic                       mem_ready_i,
    input  logic                       mem_done_i,
    input  logic                       mem_valid_i,
    input  logic [31:0]                mem_data_i,
    output logic [$clog2(DEPTH):0]     occupancy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DRAIN_WAIT = 2'd1,
        S_HOLD       = 2'd2,
        S_FWD_WAIT   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [BW_ADDR-1:0] r_fifo_add  [DEPTH];
    logic [31:0]        r_fifo_data [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW:0]        r_count;

    logic               r_held;
    logic               r_h_block;
    logic               r_h_rw;
    logic               r_h_clear;
    logic [BW_ADDR-1:0] r_h_add;

    logic               r_ack;
    // Holds core_ready_o low during reset and releases it on the first edge after.
    logic               r_run;

    logic w_empty;
    logic w_full;
    logic w_accept;
    logic w_posted;
    logic w_push;
    logic w_capture;
    logic w_drain_issue;
    logic w_fwd_issue;
    logic w_pop;
    logic w_fwd_xfer;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);

    // Accepting is only possible with no held request, so a posted ack can
    // never coincide with a forwarded done on core_done_o.
    assign core_ready_o = r_run && !r_held && !w_full &&
                          ((r_state == S_IDLE) || (r_state == S_DRAIN_WAIT));

    assign w_accept  = core_req_i && core_ready_o;
    assign w_posted  = core_rw_i && !core_reqBlock_i && !core_clear_i;
    assign w_push    = w_accept && w_posted;
    assign w_capture = w_accept && !w_posted;

    // Posted writes always go out before a held request.
    assign w_drain_issue = ((r_state == S_IDLE) || (r_state == S_HOLD)) && !w_empty;
    assign w_fwd_issue   = (r_state == S_HOLD) && w_empty;
    assign w_pop         = w_drain_issue && mem_ready_i;
    assign w_fwd_xfer    = w_fwd_issue && mem_ready_i;

    // State register
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop)          w_next = S_DRAIN_WAIT;
                else if (w_capture) w_next = S_HOLD;
            end
            S_DRAIN_WAIT: begin
                // A request may have been captured while the drain was in flight.
                if (mem_done_i) w_next = (r_held || w_capture) ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (w_pop)           w_next = S_DRAIN_WAIT;
                else if (w_fwd_xfer) w_next = S_FWD_WAIT;
            end
            S_FWD_WAIT: begin
                if (mem_done_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_req_o      = 1'b0;
        mem_reqBlock_o = 1'b0;
        mem_rw_o       = 1'b0;
        mem_clear_o    = 1'b0;
        mem_add_o      = '0;
        mem_data_o     = '0;
        if (w_drain_issue) begin
            mem_req_o  = 1'b1;
            mem_rw_o   = 1'b1;
            mem_add_o  = r_fifo_add[r_rd_ptr];
            mem_data_o = r_fifo_data[r_rd_ptr];
        end else if (w_fwd_issue) begin
            mem_req_o      = 1'b1;
            mem_reqBlock_o = r_h_block;
            mem_rw_o       = r_h_rw;
            mem_clear_o    = r_h_clear;
            mem_add_o      = r_h_add;
            mem_data_o     = core_data_i;
        end else if (r_state == S_FWD_WAIT) begin
            // Later beats of a block write stream straight through.
            mem_data_o = core_data_i;
        end
    end

    assign core_valid_o = (r_state == S_FWD_WAIT) && mem_valid_i;
    assign core_data_o  = (r_state == S_FWD_WAIT) ? mem_data_i : 32'd0;
    assign core_done_o  = r_ack || ((r_state == S_FWD_WAIT) && mem_done_i);
    assign occupancy_o  = r_count;

    // FIFO pointers, fill level, posted ack, run flag
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ack    <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_ack <= w_push;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the entry is not valid.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_fifo_add[r_wr_ptr]  <= core_add_i;
            r_fifo_data[r_wr_ptr] <= core_data_i;
        end
    end

    // Hold register for the single outstanding non-posted request
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_held    <= 1'b0;
            r_h_block <= 1'b0;
            r_h_rw    <= 1'b0;
            r_h_clear <= 1'b0;
            r_h_add   <= '0;
        end else if (w_capture) begin
            r_held    <= 1'b1;
            r_h_block <= core_reqBlock_i;
            r_h_rw    <= core_rw_i;
            r_h_clear <= core_clear_i;
            r_h_add   <= core_add_i;
        end else if (w_fwd_xfer) begin
            r_held <= 1'b0;
        end
    end

endmodule
